// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Constants and types shared by the LCD image controller and its scan-out
//   stage. It holds the frame geometry, the pixel and IRAM widths, the default
//   blanking gap and the scan state encoding.
//   It also provides a clog2 helper that never returns 0, so that counters
//   always have a legal width.
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam int LCD_IMG_W     = 8;   // pixels per line
    localparam int LCD_IMG_H     = 8;   // lines per frame
    localparam int LCD_DATA_W    = 8;   // pixel width
    localparam int LCD_ADDR_W    = 6;   // IRAM address width
    localparam int LCD_BLANK_CYC = 2;   // idle cycles after each line

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BLANK = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_scan_fifo.sv
// ---------------------------------------------------------------------------
// lcd_scan_fifo
//   A two-entry pixel FIFO. The head entry is a register that drives the
//   output stream directly. The tail entry is a skid slot that is only
//   occupied while the head is stalled.
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   push, push_data write one pixel (caller guarantees count < 2 or pop)
//   pop             remove the head (caller guarantees count > 0)
//   head_data       current head pixel (registered)
//   count           occupancy, 0..2
// ---------------------------------------------------------------------------
module lcd_scan_fifo
    import lcd_pkg::*;
#(
    parameter int DATA_W = LCD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the new pixel lands behind whatever remains.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = head_q;
    assign count     = count_q;

endmodule

// File: rtl/lcd_frame_scanout.sv
// ---------------------------------------------------------------------------
// lcd_frame_scanout
//   Reads a finished IMG_W x IMG_H frame back from IRAM and streams it to the
//   panel over a valid/ready link. The block adds sof/eol/eof markers. After
//   every line except the last it inserts a BLANK_CYC idle gap.
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   start, transpose      frame request (IDLE only), column-major scan select
//   ram_rd, ram_addr      IRAM read strobe/address (address holds when idle)
//   ram_q                 IRAM data, valid one cycle after ram_rd
//   pix_valid, pix_ready  stream handshake
//   pix_data              pixel
//   pix_sof/eol/eof       frame/line markers, qualified by pix_valid
//   busy, frame_done      frame in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module lcd_frame_scanout
    import lcd_pkg::*;
#(
    parameter int IMG_W     = LCD_IMG_W,
    parameter int IMG_H     = LCD_IMG_H,
    parameter int DATA_W    = LCD_DATA_W,
    parameter int ADDR_W    = LCD_ADDR_W,
    parameter int BLANK_CYC = LCD_BLANK_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              transpose,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam int PIX_N = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(PIX_N + 1);
    localparam int BLK_W = clog2_min1(BLANK_CYC);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(PIX_N);
    // A transposed scan of a non-square image would not be a permutation of IRAM.
    localparam logic             SQUARE    = (IMG_W == IMG_H);

    scan_state_e       state_q, state_d;
    logic              trans_q, trans_d;
    logic [ROW_W-1:0]  f_row_q, f_row_d;
    logic [COL_W-1:0]  f_col_q, f_col_d;
    logic [CNT_W-1:0]  f_cnt_q, f_cnt_d;
    logic [ROW_W-1:0]  o_row_q, o_row_d;
    logic [COL_W-1:0]  o_col_q, o_col_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              in_flight_q, in_flight_d;
    logic [BLK_W-1:0]  blank_q, blank_d;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              accept;
    logic              fetch_en;
    logic [2:0]        occupancy;
    logic [ADDR_W-1:0] fetch_addr;

    lcd_scan_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight_q),
        .push_data (ram_q),
        .pop       (accept),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    // The stream is gated by state, so pixels prefetched during BLANK stay hidden.
    assign pix_valid  = (state_q == ST_RUN) && (fifo_count != 2'd0);
    assign accept     = pix_valid && pix_ready;
    assign pix_data   = fifo_head;
    assign pix_sof    = pix_valid && (o_row_q == '0) && (o_col_q == '0);
    assign pix_eol    = pix_valid && (o_col_q == COL_LAST);
    assign pix_eof    = pix_eol && (o_row_q == ROW_LAST);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);

    // Pixels held plus the read in flight, counted after this cycle's pop.
    // Capping this at 2 means the two-entry FIFO can never overflow.
    // Counting the outgoing pixel as already gone keeps one pixel per cycle
    // flowing when the panel is always ready.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, accept};
    assign fetch_en  = ((state_q == ST_RUN) || (state_q == ST_BLANK)) && (f_cnt_q < PIX_TOTAL);
    assign ram_rd    = fetch_en && (occupancy < 3'd2);

    assign fetch_addr = trans_q ? (ADDR_W'(f_col_q) * ADDR_W'(IMG_W) + ADDR_W'(f_row_q))
                                : (ADDR_W'(f_row_q) * ADDR_W'(IMG_W) + ADDR_W'(f_col_q));
    assign ram_addr   = ram_rd ? fetch_addr : ram_addr_q;

    always_comb begin
        state_d     = state_q;
        trans_d     = trans_q;
        f_row_d     = f_row_q;
        f_col_d     = f_col_q;
        f_cnt_d     = f_cnt_q;
        o_row_d     = o_row_q;
        o_col_d     = o_col_q;
        ram_addr_d  = ram_addr_q;
        blank_d     = blank_q;
        in_flight_d = ram_rd;

        // The fetch side runs ahead of the output and walks the frame in output order.
        if (ram_rd) begin
            ram_addr_d = fetch_addr;
            f_cnt_d    = f_cnt_q + CNT_W'(1);
            if (f_col_q == COL_LAST) begin
                f_col_d = '0;
                f_row_d = f_row_q + ROW_W'(1);
            end else begin
                f_col_d = f_col_q + COL_W'(1);
            end
        end

        // The output-side position tracks only accepted beats and drives the markers.
        if (accept) begin
            if (o_col_q == COL_LAST) begin
                o_col_d = '0;
                o_row_d = o_row_q + ROW_W'(1);
            end else begin
                o_col_d = o_col_q + COL_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    trans_d = transpose && SQUARE;
                    f_row_d = '0;
                    f_col_d = '0;
                    f_cnt_d = '0;
                    o_row_d = '0;
                    o_col_d = '0;
                end
            end
            ST_RUN: begin
                if (accept && pix_eol) begin
                    if (pix_eof) begin
                        state_d = ST_DONE;
                    end else if (BLANK_CYC > 0) begin
                        state_d = ST_BLANK;
                        blank_d = '0;
                    end
                end
            end
            ST_BLANK: begin
                if (blank_q == BLK_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    blank_d = blank_q + BLK_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            trans_q     <= 1'b0;
            f_row_q     <= '0;
            f_col_q     <= '0;
            f_cnt_q     <= '0;
            o_row_q     <= '0;
            o_col_q     <= '0;
            ram_addr_q  <= '0;
            in_flight_q <= 1'b0;
            blank_q     <= '0;
        end else begin
            state_q     <= state_d;
            trans_q     <= trans_d;
            f_row_q     <= f_row_d;
            f_col_q     <= f_col_d;
            f_cnt_q     <= f_cnt_d;
            o_row_q     <= o_row_d;
            o_col_q     <= o_col_d;
            ram_addr_q  <= ram_addr_d;
            in_flight_q <= in_flight_d;
            blank_q     <= blank_d;
        end
    end

endmodule

// File: tb/tb_lcd_frame_scanout.sv
`timescale 1ns/1ps
module tb_lcd_frame_scanout;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int BC = 2;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          transpose = 1'b0;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [DW-1:0] pix_data;
    logic          pix_sof, pix_eol, pix_eof, busy, frame_done;

    always #5 clk = ~clk;

    lcd_frame_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .transpose  (transpose),
        .ram_rd     (ram_rd),
        .ram_addr   (ram_addr),
        .ram_q      (ram_q),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // IRAM model: one-cycle read latency.
    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    beat_t exp_q[$];

    // Reference model: the frame is H lines of W pixels. Line r, position c
    // comes from r*W+c in a row-major scan and from c*W+r in a transposed scan.
    task automatic push_frame(input logic t);
        beat_t b;
        int r, c, a;
        for (int k = 0; k < N; k++) begin
            r = k / W;
            c = k % W;
            a = t ? (c * W + r) : (r * W + c);
            b.data = mem[a];
            b.sof  = (k == 0);
            b.eol  = (c == W - 1);
            b.eof  = (k == N - 1);
            exp_q.push_back(b);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = random ~50%, 2 = never ready.
    int ready_mode = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom() % 2) == 1;
            default: pix_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    int          reads_issued = 0;
    int          beats_acc = 0;
    int          done_cnt = 0;
    int          neg_idx = 0;
    int          last_acc_idx = 0;
    int          blank_left = 0;
    logic        have_last = 1'b0;
    logic        last_eol = 1'b0;
    logic        last_eof = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_eof_acc = 1'b0;
    logic        prev_done = 1'b0;
    beat_t       prev_beat = '0;
    logic [AW-1:0] last_addr = '0;

    initial forever begin
        beat_t cur;
        beat_t e;
        logic  acc;
        @(negedge clk);
        if (!reset) begin
            reads_issued = 0;
            beats_acc    = 0;
            blank_left   = 0;
            have_last    = 1'b0;
            prev_stall   = 1'b0;
            prev_eof_acc = 1'b0;
            prev_done    = 1'b0;
            last_addr    = '0;
            exp_q.delete();
            continue;
        end
        neg_idx++;
        acc = pix_valid && pix_ready;
        cur = {pix_data, pix_sof, pix_eol, pix_eof};

        if (prev_stall) begin
            check("stall_valid", int'(pix_valid), 1);
            check("stall_hold", int'(cur), int'(prev_beat));
        end
        if (blank_left > 0) begin
            check("blank_idle", int'(pix_valid), 0);
            blank_left--;
        end
        if (prev_eof_acc || frame_done)
            check("frame_done_after_eof", int'(frame_done), int'(prev_eof_acc));
        if (prev_done)
            check("busy_after_done", int'(busy), 0);

        if (ram_rd) begin
            check("fetch_credit", int'((reads_issued - beats_acc - int'(acc)) < 2), 1);
            reads_issued++;
            last_addr = ram_addr;
        end else begin
            check("addr_hold", int'(ram_addr), int'(last_addr));
        end

        if (acc) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got 0x%0h expected no beat at %0t", cur, $time);
            end else begin
                e = exp_q.pop_front();
                check("beat", int'(cur), int'(e));
            end
            beats_acc++;
            if (have_last && !last_eof && ready_mode == 0)
                check("beat_gap", neg_idx - last_acc_idx, last_eol ? BC + 1 : 1);
            have_last    = 1'b1;
            last_acc_idx = neg_idx;
            last_eol     = pix_eol;
            last_eof     = pix_eof;
            if (pix_eol && !pix_eof) blank_left = BC;
        end

        prev_eof_acc = acc && pix_eof;
        prev_done    = frame_done;
        if (frame_done) done_cnt++;
        prev_stall   = pix_valid && !pix_ready;
        prev_beat    = cur;
    end

    task automatic start_frame(input logic t);
        push_frame(t);
        @(posedge clk);
        #1;
        transpose = t;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int d0, input int b0);
        for (int i = 0; i < 2000 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout %s: got no frame_done expected one", tag);
        end
        repeat (4) @(posedge clk);
        check("done_pulses", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        check("frame_beats", beats_acc - b0, N);
        $display("frame %s: %0d beats accepted", tag, beats_acc - b0);
    endtask

    task automatic fill_mem(input logic identity);
        for (int a = 0; a < N; a++) mem[a] = identity ? DW'(a) : DW'($urandom());
    endtask

    initial begin
        int d0, b0, r0, k;
        logic first_rd;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({ram_rd, ram_addr, pix_valid, pix_data, pix_sof,
                                     pix_eol, pix_eof, busy, frame_done}), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 1: identity RAM, always ready, latency of the first beat.
        fill_mem(1'b1);
        ready_mode = 0;
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'b0);
        first_rd = 1'b0;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) first_rd = ram_rd;
            if (pix_valid) begin k = i; break; end
        end
        check("first_read_cycle", int'(first_rd), 1);
        check("first_valid_latency", k, 3);
        finish_frame("row_major", d0, b0);

        // 2: transposed scan.
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'b1);
        finish_frame("transposed", d0, b0);

        // 3: random data, random backpressure.
        fill_mem(1'b0);
        ready_mode = 1;
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'b0);
        finish_frame("random_ready", d0, b0);
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'($urandom() % 2));
        finish_frame("random_ready_t", d0, b0);

        // 4: panel stalled for 20 cycles after start.
        fill_mem(1'b0);
        ready_mode = 2;
        repeat (2) @(posedge clk);
        d0 = done_cnt; b0 = beats_acc; r0 = reads_issued;
        start_frame(1'b0);
        repeat (20) @(posedge clk);
        check("stalled_reads", reads_issued - r0, 2);
        ready_mode = 1;
        finish_frame("stalled_start", d0, b0);

        // 5: start pulsed mid-frame.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'b0);
        for (int i = 0; i < 500 && (beats_acc - b0) < 20; i++) @(posedge clk);
        check("reached_beat20", int'((beats_acc - b0) >= 20), 1);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        finish_frame("restart_ignored", d0, b0);

        // 6: reset at beat 30, then a clean frame.
        fill_mem(1'b0);
        ready_mode = 1;
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'b0);
        for (int i = 0; i < 2000 && (beats_acc - b0) < 30; i++) @(posedge clk);
        check("reached_beat30", int'((beats_acc - b0) >= 30), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_outputs", int'({ram_rd, ram_addr, pix_valid, pix_data, pix_sof,
                                     pix_eol, pix_eof, busy, frame_done}), 0);
        repeat (3) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        check("abort_no_done_after", done_cnt - d0, 0);
        d0 = done_cnt; b0 = beats_acc;
        start_frame(1'b0);
        finish_frame("after_reset", d0, b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
